depth_test_unit: RTL and testbench
==================================

Name: depth_test_unit

Overview:
- Sits directly downstream of the rasterizer backend; consumes its per-pixel fragment stream (address, write-enable, depth, colour).
- Performs a z-buffer depth test against a synchronous-read depth BRAM; on pass, writes depth and colour to the depth and frame buffers.
- Also owns a frame-clear sweep that initialises both buffers before a new frame.
- The backend cannot be stalled, so the block accepts one fragment per cycle while not clearing, with no backpressure.

Parameters:
- DATAWIDTH, 12, depth word width (unsigned).
- COLORWIDTH, 4, colour word width.
- ADDRWIDTH, 16, buffer address width.
- SCREEN_WIDTH, 160, pixels per row.
- SCREEN_HEIGHT, 120, rows; FB_SIZE = SCREEN_WIDTH*SCREEN_HEIGHT, must be ≤ 2^ADDRWIDTH.
- CLEAR_COLOR, 0, colour written by the clear sweep.

Ports:
- clk, input, 1, clock.
- rstn, input, 1, asynchronous active-low reset.
- i_fb_addr, input, ADDRWIDTH, fragment pixel address.
- i_fb_write_en, input, 1, fragment valid (inside triangle).
- i_depth, input, DATAWIDTH, fragment depth.
- i_color, input, COLORWIDTH, fragment colour.
- i_finished, input, 1, one-cycle pulse after the last fragment of a frame.
- i_clear, input, 1, one-cycle pulse that requests a buffer clear.
- o_zb_read_addr, output, ADDRWIDTH, depth BRAM read address (combinational).
- i_zb_read_data, input, DATAWIDTH, depth BRAM data, valid 1 cycle after the address.
- o_zb_write_addr, output, ADDRWIDTH, depth BRAM write address.
- o_zb_write_en, output, 1, depth BRAM write strobe.
- o_zb_write_data, output, DATAWIDTH, depth BRAM write data.
- o_fb_write_addr, output, ADDRWIDTH, frame buffer write address.
- o_fb_write_en, output, 1, frame buffer write strobe.
- o_fb_write_data, output, COLORWIDTH, frame buffer write data.
- o_ready, output, 1, high when fragments are accepted.
- o_clear_busy, output, 1, high while a clear is pending or running.
- o_frame_done, output, 1, one-cycle pulse when the frame's last write has been issued.

Behaviour:
- Reset values: every registered output is 0, and the FSM enters IDLE. o_ready is 1 one cycle after reset is released.
- FSM states:
  - IDLE: process fragments. An i_clear pulse moves to DRAIN.
  - DRAIN: wait until the pipeline is empty (2 cycles), then move to CLEAR.
  - CLEAR: count 0..FB_SIZE-1, one address per cycle. After address FB_SIZE-1, move to IDLE.
- o_ready = (state == IDLE). o_clear_busy = (state != IDLE).
- Fragments presented while o_ready = 0 are dropped silently. i_clear while busy is ignored.
- Pipeline, for a fragment presented in cycle t:
  - S0 (cycle t): o_zb_read_addr = i_fb_addr.
  - S1 (cycle t+1): compare the fragment against the stored depth, register the result.
  - S2 (cycle t+2): write strobes are asserted for one cycle with addr = i_fb_addr, depth and colour.
  - Fixed latency is 2 cycles. The throughput is 1 fragment/cycle.
- Pass rule: i_depth < stored (unsigned, strict). A fail produces no writes.
- Writes to the depth and frame buffers are always simultaneous and use the same address.
- Hazard forwarding (mandatory). The BRAM is read-first, so a write issued in S2 is not visible to reads in flight at distance 1 or 2.
  - At S1 compare, the stored depth is taken in this priority order:
    1. The S2 pending write, if valid and its address matches.
    2. Else a 1-cycle-delayed copy of the previous write, if valid and its address matches.
    3. Else i_zb_read_data.
  - Back-to-back same-address fragments must therefore resolve exactly as sequential processing would.
- Clear sweep:
  - Writes DEPTH_MAX (all ones) and CLEAR_COLOR to address n in cycle n of CLEAR.
  - The address counter does not wrap; the FSM exits at FB_SIZE-1.
- Frame done: i_finished is delayed 2 cycles and drives o_frame_done, aligned with the last possible fragment write. Only i_finished arriving while o_ready = 1 is honoured.
- Reset mid-operation: asynchronous. All pipeline valids, the counter and the FSM clear immediately, and write strobes drop in the same cycle. A partially completed clear is not resumed.

Optional Feature:
- Macro: DEPTH_TEST_STATS_EN.
- When defined, adds output ports o_pass_count and o_fail_count, each 32 bits.
  - Each is a saturating counter of depth-test passes or fails.
  - Both counters are zeroed on reset and at the start of each CLEAR.
  - Fragments dropped while busy are not counted.
- When undefined: no ports and no counter logic; behaviour is otherwise identical.

Test Plan:
- Clear then single fragment:
  - Stimulus: i_clear; wait for o_clear_busy = 0; then fragment addr 5, depth 0x100, colour 0x3.
  - Response: CLEAR writes 19200 addresses with 0xFFF/0x0. The fragment causes writes at t+2 of addr 5, 0x100, 0x3.
- Depth fail:
  - Stimulus: after the above, fragment addr 5, depth 0x200.
  - Response: no write strobe in t+2.
- Forwarding at distance 1:
  - Stimulus: consecutive cycles to addr 7 with depth 0x300, then 0x280.
  - Response: both pass, writes 0x300 then 0x280. Reversing the order gives one write only (0x280).
- Forwarding at distance 2:
  - Stimulus: addr 9 depth 0x050, an idle cycle, then addr 9 depth 0x060.
  - Response: the second fragment fails (compared against 0x050, not 0xFFF).
- Busy drop and frame done:
  - Stimulus: fragment during CLEAR, then i_finished in IDLE.
  - Response: the fragment is dropped and no write occurs. o_frame_done pulses exactly 2 cycles after i_finished.
- Async reset:
  - Stimulus: assert rstn = 0 mid-CLEAR at address 1000.
  - Response: write strobes are 0 immediately, and the FSM returns to IDLE with o_ready = 1 after release.

Source files
------------

// File: rtl/depth_test_unit.sv
// depth_test_unit: z-buffer depth test on the rasterizer fragment stream, plus a frame-clear sweep.
// Latency: fragment presented in cycle t -> depth/colour write strobes in cycle t+2; 1 fragment/cycle.
// Backpressure: none; fragments (and i_finished) arriving while o_ready=0 are silently dropped.
//
// Ports: fragment in (i_fb_addr/i_fb_write_en/i_depth/i_color), i_finished, i_clear;
//        depth BRAM read (o_zb_read_addr, i_zb_read_data one cycle later, read-first);
//        depth BRAM write (o_zb_write_*), frame buffer write (o_fb_write_*);
//        status o_ready, o_clear_busy, o_frame_done.
// Optional macro DEPTH_TEST_STATS_EN adds saturating o_pass_count / o_fail_count outputs.
module depth_test_unit #(
    parameter int                  DATAWIDTH     = 12,
    parameter int                  COLORWIDTH    = 4,
    parameter int                  ADDRWIDTH     = 16,
    parameter int                  SCREEN_WIDTH  = 160,
    parameter int                  SCREEN_HEIGHT = 120,
    parameter logic [COLORWIDTH-1:0] CLEAR_COLOR = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDRWIDTH-1:0]  i_fb_addr,
    input  logic                  i_fb_write_en,
    input  logic [DATAWIDTH-1:0]  i_depth,
    input  logic [COLORWIDTH-1:0] i_color,
    input  logic                  i_finished,
    input  logic                  i_clear,
    output logic [ADDRWIDTH-1:0]  o_zb_read_addr,
    input  logic [DATAWIDTH-1:0]  i_zb_read_data,
    output logic [ADDRWIDTH-1:0]  o_zb_write_addr,
    output logic                  o_zb_write_en,
    output logic [DATAWIDTH-1:0]  o_zb_write_data,
    output logic [ADDRWIDTH-1:0]  o_fb_write_addr,
    output logic                  o_fb_write_en,
    output logic [COLORWIDTH-1:0] o_fb_write_data,
    output logic                  o_ready,
    output logic                  o_clear_busy,
`ifdef DEPTH_TEST_STATS_EN
    output logic [31:0]           o_pass_count,
    output logic [31:0]           o_fail_count,
`endif
    output logic                  o_frame_done
);

    localparam int                   FB_SIZE   = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(FB_SIZE - 1);
    localparam logic [DATAWIDTH-1:0] DEPTH_MAX = '1;

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t                 state, next_state;
    logic                   ready_q, busy_q;
    logic                   drain_cnt;
    logic [ADDRWIDTH-1:0]   clr_addr;

    // S1: fragment waiting for BRAM data
    logic                   s1_vld;
    logic [ADDRWIDTH-1:0]   s1_addr;
    logic [DATAWIDTH-1:0]   s1_depth;
    logic [COLORWIDTH-1:0]  s1_color;
    // S2: passed fragment, write being issued this cycle
    logic                   s2_we;
    logic [ADDRWIDTH-1:0]   s2_addr;
    logic [DATAWIDTH-1:0]   s2_depth;
    logic [COLORWIDTH-1:0]  s2_color;
    // S3: write issued last cycle; BRAM is read-first so reads launched with it still miss it
    logic                   s3_we;
    logic [ADDRWIDTH-1:0]   s3_addr;
    logic [DATAWIDTH-1:0]   s3_depth;

    logic                   fin_d1, fin_d2;
    logic                   accept;
    logic                   clearing;
    logic [DATAWIDTH-1:0]   stored;
    logic                   pass;

    assign accept         = i_fb_write_en & ready_q;
    assign clearing       = (state == CLEAR);
    assign o_zb_read_addr = i_fb_addr;
    assign o_ready        = ready_q;
    assign o_clear_busy   = busy_q;
    assign o_frame_done   = fin_d2;

    // Newest in-flight write to the same address wins over the BRAM data.
    always_comb begin
        stored = i_zb_read_data;
        if (s2_we && (s2_addr == s1_addr)) begin
            stored = s2_depth;
        end else if (s3_we && (s3_addr == s1_addr)) begin
            stored = s3_depth;
        end
        pass = s1_vld && (s1_depth < stored);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_clear && ready_q)       next_state = DRAIN;
            DRAIN:   if (drain_cnt)                next_state = CLEAR;
            CLEAR:   if (clr_addr == LAST_ADDR)    next_state = IDLE;
            default:                               next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            drain_cnt <= 1'b0;
            clr_addr  <= '0;
        end else begin
            state     <= next_state;
            ready_q   <= (next_state == IDLE);
            busy_q    <= (next_state != IDLE);
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (clearing && (clr_addr != LAST_ADDR)) begin
                clr_addr <= clr_addr + 1'b1;
            end else begin
                clr_addr <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld   <= 1'b0;
            s1_addr  <= '0;
            s1_depth <= '0;
            s1_color <= '0;
            s2_we    <= 1'b0;
            s2_addr  <= '0;
            s2_depth <= '0;
            s2_color <= '0;
            s3_we    <= 1'b0;
            s3_addr  <= '0;
            s3_depth <= '0;
            fin_d1   <= 1'b0;
            fin_d2   <= 1'b0;
        end else begin
            s1_vld   <= accept;
            s1_addr  <= i_fb_addr;
            s1_depth <= i_depth;
            s1_color <= i_color;
            s2_we    <= pass;
            s2_addr  <= s1_addr;
            s2_depth <= s1_depth;
            s2_color <= s1_color;
            s3_we    <= s2_we;
            s3_addr  <= s2_addr;
            s3_depth <= s2_depth;
            fin_d1   <= i_finished & ready_q;
            fin_d2   <= fin_d1;
        end
    end

    // The sweep owns the write ports during CLEAR; the pipeline is already drained then.
    always_comb begin
        o_zb_write_en   = s2_we | clearing;
        o_zb_write_addr = clearing ? clr_addr  : s2_addr;
        o_zb_write_data = clearing ? DEPTH_MAX : s2_depth;
        o_fb_write_en   = s2_we | clearing;
        o_fb_write_addr = clearing ? clr_addr    : s2_addr;
        o_fb_write_data = clearing ? CLEAR_COLOR : s2_color;
    end

`ifdef DEPTH_TEST_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_pass_count <= '0;
            o_fail_count <= '0;
        end else if ((next_state == CLEAR) && (state != CLEAR)) begin
            o_pass_count <= '0;
            o_fail_count <= '0;
        end else if (s1_vld) begin
            if (pass) begin
                if (o_pass_count != '1) o_pass_count <= o_pass_count + 1'b1;
            end else begin
                if (o_fail_count != '1) o_fail_count <= o_fail_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_depth_test_unit.sv
// tb_depth_test_unit: self-checking bench for depth_test_unit with a read-first BRAM model.
// Reference: sequential per-fragment z-test on plain arrays, timing derived from the 2-cycle latency.
// Stimulus: directed plan cases followed by randomized fragment bursts.
module tb_depth_test_unit;
    localparam int AW = 16;
    localparam int DW = 12;
    localparam int CW = 4;
    localparam int FB = 160 * 120;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW-1:0] i_fb_addr = '0;
    logic          i_fb_write_en = 1'b0;
    logic [DW-1:0] i_depth = '0;
    logic [CW-1:0] i_color = '0;
    logic          i_finished = 1'b0;
    logic          i_clear = 1'b0;
    logic [AW-1:0] zb_ra;
    logic [DW-1:0] zb_rd = '0;
    logic [AW-1:0] zb_wa, fb_wa;
    logic          zb_we, fb_we;
    logic [DW-1:0] zb_wd;
    logic [CW-1:0] fb_wd;
    logic          o_ready, o_clear_busy, o_frame_done;
`ifdef DEPTH_TEST_STATS_EN
    logic [31:0]   o_pass_count, o_fail_count;
`endif

    always #5 clk = ~clk;

    depth_test_unit dut (
        .clk(clk), .rstn(rstn),
        .i_fb_addr(i_fb_addr), .i_fb_write_en(i_fb_write_en),
        .i_depth(i_depth), .i_color(i_color),
        .i_finished(i_finished), .i_clear(i_clear),
        .o_zb_read_addr(zb_ra), .i_zb_read_data(zb_rd),
        .o_zb_write_addr(zb_wa), .o_zb_write_en(zb_we), .o_zb_write_data(zb_wd),
        .o_fb_write_addr(fb_wa), .o_fb_write_en(fb_we), .o_fb_write_data(fb_wd),
        .o_ready(o_ready), .o_clear_busy(o_clear_busy),
`ifdef DEPTH_TEST_STATS_EN
        .o_pass_count(o_pass_count), .o_fail_count(o_fail_count),
`endif
        .o_frame_done(o_frame_done)
    );

    // Read-first synchronous BRAMs (environment, not the reference).
    logic [DW-1:0] zmem [FB];
    logic [CW-1:0] fmem [FB];
    always @(posedge clk) begin
        zb_rd <= zmem[zb_ra];
        if (zb_we) zmem[zb_wa] <= zb_wd;
        if (fb_we) fmem[fb_wa] <= fb_wd;
    end

    // Reference model state
    logic [DW-1:0] rz [FB];
    logic [CW-1:0] rc [FB];
    logic          ew [4];
    logic [AW-1:0] ea [4];
    logic [DW-1:0] ed [4];
    logic [CW-1:0] ec [4];
    logic          edone [4];
    int cyc = 0;
    int ready_from = 1 << 30;
    int busy_lo = 1, busy_hi = 0;
    int clr_start = 0;
    logic clr_on = 1'b0;
    int n_pass = 0, n_fail = 0;
    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            ew[i] = 1'b0;
            edone[i] = 1'b0;
        end
        clr_on = 1'b0;
        busy_lo = 1;
        busy_hi = 0;
        n_pass = 0;
        n_fail = 0;
    endtask

    // Called at a negedge with rstn possibly already low; holds reset for 'hold' cycles.
    task automatic apply_reset(input int hold);
        rstn = 1'b0;
        #1;
        check("rst_zb_we", zb_we, 1'b0);
        check("rst_fb_we", fb_we, 1'b0);
        check("rst_busy", o_clear_busy, 1'b0);
        check("rst_ready", o_ready, 1'b0);
        check("rst_done", o_frame_done, 1'b0);
        repeat (hold) begin
            @(negedge clk);
            cyc++;
        end
        rstn = 1'b1;
        model_reset();
        ready_from = cyc + 1;
    endtask

    // One cycle: check outputs of cycle 'cyc', drive this cycle's inputs, advance the model.
    task automatic tick(input logic we, input int addr, input int depth, input int color,
                        input logic fin, input logic clr);
        int s, n, t;
        logic xw, rdy, busy;
        logic [AW-1:0] xa;
        logic [DW-1:0] xd;
        logic [CW-1:0] xc;
        s = cyc % 4;
        rdy  = (cyc >= ready_from);
        busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        if (clr_on && cyc >= clr_start && cyc < clr_start + FB) begin
            n = cyc - clr_start;
            xw = 1'b1; xa = AW'(n); xd = '1; xc = '0;
            rz[n] = '1;
            rc[n] = '0;
        end else begin
            xw = ew[s]; xa = ea[s]; xd = ed[s]; xc = ec[s];
        end
        check("ready", o_ready, rdy);
        check("clear_busy", o_clear_busy, busy);
        check("zb_we", zb_we, xw);
        check("fb_we", fb_we, xw);
        if (xw) begin
            check("zb_waddr", zb_wa, xa);
            check("zb_wdata", zb_wd, xd);
            check("fb_waddr", fb_wa, xa);
            check("fb_wdata", fb_wd, xc);
        end
        check("frame_done", o_frame_done, edone[s]);
        ew[s] = 1'b0;
        edone[s] = 1'b0;

        i_fb_write_en = we;
        i_fb_addr     = AW'(addr);
        i_depth       = DW'(depth);
        i_color       = CW'(color);
        i_finished    = fin;
        i_clear       = clr;
        #1;
        if (we) check("zb_raddr", zb_ra, AW'(addr));

        if (rdy) begin
            t = (cyc + 2) % 4;
            if (we) begin
                if (DW'(depth) < rz[addr]) begin
                    rz[addr] = DW'(depth);
                    rc[addr] = CW'(color);
                    ew[t] = 1'b1; ea[t] = AW'(addr); ed[t] = DW'(depth); ec[t] = CW'(color);
                    n_pass++;
                end else begin
                    n_fail++;
                end
            end
            if (fin) edone[t] = 1'b1;
            if (clr) begin
                busy_lo    = cyc + 1;
                busy_hi    = cyc + 2 + FB;
                clr_on     = 1'b1;
                clr_start  = cyc + 3;
                ready_from = cyc + 3 + FB;
                n_pass = 0;
                n_fail = 0;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic frag(input int addr, input int depth, input int color);
        tick(1'b1, addr, depth, color, 1'b0, 1'b0);
    endtask

    // Runs idle cycles until the model says the clear is over; bounded by construction.
    task automatic wait_clear_done();
        int guard = 0;
        while (cyc < ready_from && guard < FB + 100) begin
            idle(1);
            guard++;
        end
        check("clear_finished", o_clear_busy, 1'b0);
    endtask

    task automatic rand_phase(input int n, input int alo, input int ahi);
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, 3) != 0, int'($urandom_range(ahi, alo)),
                 int'($urandom_range(0, 4095)), int'($urandom_range(0, 15)),
                 $urandom_range(0, 31) == 0, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < FB; i++) begin
            zmem[i] = '0; fmem[i] = '0;
            rz[i] = '0;   rc[i] = '0;
        end
        model_reset();
        @(negedge clk);
        apply_reset(2);
        idle(2);

        // Clear, then single fragment, then depth fail
        tick(1'b0, 0, 0, 0, 1'b0, 1'b1);
        wait_clear_done();
        check("mem_clear_last", zmem[FB-1], 12'hFFF);
        frag(5, 'h100, 'h3);
        idle(3);
        frag(5, 'h200, 'h7);
        idle(3);

        // Forwarding at distance 1, both orders
        frag(7, 'h300, 'h1);
        frag(7, 'h280, 'h2);
        idle(2);
        frag(8, 'h280, 'h4);
        frag(8, 'h300, 'h5);
        idle(2);

        // Forwarding at distance 2
        frag(9, 'h050, 'h6);
        idle(1);
        frag(9, 'h060, 'h9);
        idle(3);

        rand_phase(400, 0, 15);
        idle(3);

        // Busy drop, finished ignored while busy, then frame done in IDLE
        tick(1'b1, 3, 'h010, 'hA, 1'b0, 1'b1);
        frag(4, 'h001, 'hB);
        tick(1'b1, 4, 'h001, 'hB, 1'b1, 1'b0);
        idle(10);
        frag(5, 'h001, 'hC);
        wait_clear_done();
        tick(1'b0, 0, 0, 0, 1'b1, 1'b0);
        idle(3);
        tick(1'b1, 12, 'h123, 'hD, 1'b1, 1'b0);
        idle(3);

        rand_phase(400, 0, 31);
        idle(3);

        // Reset mid-clear at address 1000
        tick(1'b0, 0, 0, 0, 1'b0, 1'b1);
        while (cyc < clr_start + 1000) idle(1);
        check("pre_rst_we", zb_we, 1'b1);
        check("pre_rst_addr", zb_wa, 16'd1000);
        apply_reset(3);
        idle(2);
        check("post_rst_ready", o_ready, 1'b1);
        rand_phase(400, 990, 1010);
        idle(4);

        for (int a = 0; a < 32; a++) begin
            check("zmem", zmem[a], rz[a]);
            check("fmem", fmem[a], rc[a]);
        end
        for (int a = 990; a <= 1010; a++) begin
            check("zmem_hi", zmem[a], rz[a]);
        end
`ifdef DEPTH_TEST_STATS_EN
        check("pass_count", o_pass_count, n_pass);
        check("fail_count", o_fail_count, n_fail);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
